// File: rtl/div_pkg.sv
// Shared types and helpers for the pipelined non-restoring divider.
// Consumed by pipe_nr_divider; signed operation is selected with SIGNED_DIV_EN.
package div_pkg;

    localparam int DIV_W     = 16;
    localparam int DIV_TAG_W = 4;

    localparam int S_IN  = 0;
    localparam int S_FIX = DIV_W + 1;

    function automatic int div_lat(input int w);
        return w + 2;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DIV_W:0]       prem;
        logic [DIV_W-1:0]     quot;
        logic [DIV_W-1:0]     dvsr;
        logic [DIV_TAG_W-1:0] tag;
        logic                 dbz;
        logic                 q_neg;
        logic                 r_neg;
    } stage_t;

endpackage

// File: rtl/div_nr_stage.sv
// One combinational radix-2 non-restoring iteration.
// Shifts the next dividend bit in from q and produces one quotient bit.
module div_nr_stage #(
    parameter int W = 16
) (
    input  logic [W:0]   prem,
    input  logic [W-1:0] dvsr,
    input  logic [W-1:0] q,
    output logic [W:0]   prem_nxt,
    output logic [W-1:0] q_nxt
);

    logic [W:0] sh;
    logic [W:0] d;

    always_comb begin
        sh = {prem[W-1:0], q[W-1]};
        d  = {1'b0, dvsr};
        // add/subtract chosen by the sign before the shift
        prem_nxt = prem[W] ? (sh + d) : (sh - d);
        q_nxt    = {q[W-2:0], ~prem_nxt[W]};
    end

endmodule

// File: rtl/pipe_nr_divider.sv
// Fully pipelined non-restoring divider, W+2 cycle latency, valid/ready.
// Define SIGNED_DIV_EN for two's complement operands and results.
module pipe_nr_divider
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             dbz,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LAT = div_lat(W);
    localparam int FIX = LAT - 1;

    typedef struct packed {
        logic             valid;
        logic [W:0]       prem;
        logic [W-1:0]     quot;
        logic [W-1:0]     dvsr;
        logic [TAG_W-1:0] tag;
        logic             dbz;
        logic             q_neg;
        logic             r_neg;
    } lane_t;

    lane_t st [LAT];

    logic             op_v;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [TAG_W-1:0] op_tag;

    logic stall;

    assign stall    = st[FIX].valid & ~out_ready;
    assign in_ready = ~stall;

    lane_t s0_d;

    always_comb begin
        s0_d       = '0;
        s0_d.valid = op_v;
        s0_d.tag   = op_tag;
        s0_d.dbz   = (op_b == '0);
`ifdef SIGNED_DIV_EN
        s0_d.quot  = op_a[W-1] ? -op_a : op_a;
        s0_d.dvsr  = op_b[W-1] ? -op_b : op_b;
        s0_d.q_neg = op_a[W-1] ^ op_b[W-1];
        s0_d.r_neg = op_a[W-1];
`else
        s0_d.quot  = op_a;
        s0_d.dvsr  = op_b;
`endif
    end

    logic [W:0]   it_prem [1:W];
    logic [W-1:0] it_q    [1:W];

    for (genvar g = 1; g <= W; g++) begin : g_iter
        div_nr_stage #(
            .W(W)
        ) u_iter (
            .prem     (st[g-1].prem),
            .dvsr     (st[g-1].dvsr),
            .q        (st[g-1].quot),
            .prem_nxt (it_prem[g]),
            .q_nxt    (it_q[g])
        );
    end

    lane_t        fx_d;
    logic [W-1:0] q_c;
    logic [W-1:0] r_c;

    always_comb begin
        fx_d = st[W];
        q_c  = st[W].quot;
        // the true remainder lies in [0, dvsr), so W bits are enough
        r_c  = st[W].prem[W] ? (st[W].prem[W-1:0] + st[W].dvsr)
                             : st[W].prem[W-1:0];
`ifdef SIGNED_DIV_EN
        if (st[W].q_neg) q_c = -q_c;
        if (st[W].r_neg) r_c = -r_c;
`endif
        if (st[W].dbz) q_c = '1;
        fx_d.quot = q_c;
        fx_d.prem = {1'b0, r_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_v   <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_tag <= '0;
            for (int i = 0; i < LAT; i++) st[i] <= '0;
        end else if (!stall) begin
            op_v   <= in_valid;
            op_a   <= dividend;
            op_b   <= divisor;
            op_tag <= in_tag;
            st[S_IN] <= s0_d;
            for (int i = 1; i <= W; i++) begin
                st[i]      <= st[i-1];
                st[i].prem <= it_prem[i];
                st[i].quot <= it_q[i];
            end
            st[FIX] <= fx_d;
        end
    end

    assign out_valid = st[FIX].valid;
    assign quotient  = st[FIX].quot;
    assign remainder = st[FIX].prem[W-1:0];
    assign dbz       = st[FIX].dbz;
    assign out_tag   = st[FIX].tag;

endmodule

// File: tb/tb_pipe_nr_divider.sv
// Random and directed bench for pipe_nr_divider against an arithmetic model.
// Define SIGNED_DIV_EN to exercise the two's complement build.
module tb_pipe_nr_divider;

    localparam int W   = 16;
    localparam int TW  = 4;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          dbz;
    logic [TW-1:0] out_tag;

    pipe_nr_divider #(
        .W     (W),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dbz;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   errs    = 0;
    int   checks  = 0;
    int   emitted = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_div(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [TW-1:0] t);
        exp_t e;
        int   sa, sd, qq, rr;
        e.tag = t;
        e.dbz = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef SIGNED_DIV_EN
            sa  = $signed(a);
            sd  = $signed(b);
            qq  = sa / sd;
            rr  = sa % sd;
`else
            sa  = int'(a);
            sd  = int'(b);
            qq  = sa / sd;
            rr  = sa % sd;
`endif
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious", 32'd1, 32'd0);
                end else begin
                    check("quot", quotient, sb[0].q);
                    check("rem", remainder, sb[0].r);
                    check("dbz", dbz, sb[0].dbz);
                    check("tag", out_tag, sb[0].tag);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        emitted++;
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(ref_div(dividend, divisor, in_tag));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t);
        int   n;
        logic ok;
        n        = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        in_tag   = t;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] t, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ed);
        int n;
        send(a, b, t);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        check("latency", n, LAT);
        check("dir_q", quotient, eq);
        check("dir_r", remainder, er);
        check("dir_dbz", dbz, ed);
        check("dir_tag", out_tag, t);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_dvsr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '0;
        if (sel < 4)  return W'($urandom_range(1, 15));
        return W'($urandom);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     e0;
        time    t0;
        time    t1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ovalid", out_valid, 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dbz", dbz, 32'd0);
        check("rst_tag", out_tag, 32'd0);
        check("rst_iready", in_ready, 32'd1);

        run_one(16'd1000, 16'd7, 4'd1, 16'd142, 16'd6, 1'b0);
        run_one(16'd65535, 16'd1, 4'd2, 16'd65535, 16'd0, 1'b0);
        run_one(16'd5, 16'd9, 4'd3, 16'd0, 16'd5, 1'b0);

        run_one(16'd1234, 16'd0, 4'd4, 16'hFFFF, 16'd1234, 1'b1);
        run_one(16'd20, 16'd3, 4'd5, 16'd6, 16'd2, 1'b0);

`ifdef SIGNED_DIV_EN
        run_one(16'hFFF9, 16'd2, 4'd6, 16'hFFFD, 16'hFFFF, 1'b0);
        run_one(16'd7, 16'hFFFE, 4'd7, 16'hFFFD, 16'd1, 1'b0);
        run_one(16'h8000, 16'hFFFF, 4'd8, 16'h8000, 16'd0, 1'b0);
`endif

        e0 = emitted;
        t0 = $time;
        for (int i = 0; i < 100; i++)
            send(W'($urandom), rnd_dvsr(), TW'(i));
        t1 = $time;
        check("b2b_cycles", 32'((t1 - t0) / 10), 32'd100);
        drain();
        check("b2b_count", emitted - e0, 32'd100);

        e0 = emitted;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(W'($urandom), rnd_dvsr(), TW'(i));
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 60);
                check("stall_fill", out_valid, 32'd1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_rdy", in_ready, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", emitted - e0, 32'd30);

        e0 = emitted;
        fork
            begin
                for (int i = 0; i < 50; i++)
                    send(W'($urandom), rnd_dvsr(), TW'(i));
            end
            begin
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        check("mixed_count", emitted - e0, 32'd50);

        e0 = emitted;
        for (int i = 0; i < 10; i++)
            send(W'($urandom), rnd_dvsr(), TW'(i));
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst2_ovalid", out_valid, 32'd0);
        check("rst2_quot", quotient, 32'd0);
        check("rst2_rem", remainder, 32'd0);
        check("rst2_dbz", dbz, 32'd0);
        check("rst2_tag", out_tag, 32'd0);
        check("rst2_iready", in_ready, 32'd1);
        repeat (LAT + 10) @(posedge clk);
        #1;
        check("rst2_flushed", emitted - e0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
